// File: rtl/fios_res_collector.sv
// fios_res_collector: word-serial result collector and final-reduction stage.
// Collects s result words from the FIOS multiplier, LSW first, and assembles R.
// If FIOS_FINAL_SUB_EN is defined, it then computes R - p one word per cycle
// and outputs D when R >= p, or R when R < p.
// If FIOS_FINAL_SUB_EN is undefined, it outputs R unreduced and p_i is unused.
// The reduced result is presented with a valid/ready handshake.
module fios_res_collector #(
  parameter int s = 8,
  parameter int W = 17
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             res_valid_i,
  input  logic [W-1:0]     res_i,
  input  logic [s*W-1:0]   p_i,
  output logic             busy_o,
  output logic [s*W-1:0]   result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             overflow_o
);

  localparam int CW = (s > 1) ? $clog2(s) : 1;
  localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(s - 1);
  // Counter value after word 0 is captured; wraps to 0 for a single-word result.
  localparam logic [CW-1:0] FIRST_CNT = (s == 1) ? ZERO_CNT : ONE_CNT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SUB     = 2'd2,
    OUT     = 2'd3
  } state_t;

`ifdef FIOS_FINAL_SUB_EN
  localparam state_t AFTER_COLLECT = SUB;
`else
  localparam state_t AFTER_COLLECT = OUT;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [s*W-1:0]   result_q, result_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic [s*W-1:0]   r_q, r_d;
  logic             wr_en_s;
  logic [CW-1:0]    wr_idx_s;
  logic [s*W-1:0]   sel_s;

`ifdef FIOS_FINAL_SUB_EN
  logic [s*W-1:0]   d_q, d_d;
  logic             sub_en_s;
  logic [W-1:0]     r_k_s;
  logic [W-1:0]     p_k_s;
  logic [W:0]       diff_s;

  // One word of R - p - borrow. Bit W of the result is the outgoing borrow.
  always_comb begin
    r_k_s  = r_q[cnt_q*W +: W];
    p_k_s  = p_i[cnt_q*W +: W];
    diff_s = {1'b0, r_k_s} - {1'b0, p_k_s} - {{W{1'b0}}, borrow_q};
  end

  // Final select: a clear borrow means R >= p, so the difference is the result.
  always_comb begin
    if (borrow_q) begin
      sel_s = r_q;
    end else begin
      sel_s = d_q;
    end
  end

  // Difference bank write, one word per SUB cycle.
  always_comb begin
    d_d = d_q;
    if (sub_en_s) begin
      d_d[cnt_q*W +: W] = diff_s[W-1:0];
    end else begin
      d_d = d_q;
    end
  end

  // Difference bank storage. It needs no reset because it is rewritten before use.
  always_ff @(posedge clock_i) begin
    d_q <= d_d;
  end
`else
  logic unused_p_s;
  assign unused_p_s = ^p_i;

  // Without final subtraction, the raw R, which is in [0, 2p), is the result.
  always_comb begin
    sel_s = r_q;
  end
`endif

  // State and control registers, with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= ZERO_CNT;
      borrow_q   <= 1'b0;
      result_q   <= {(s*W){1'b0}};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          if (s == 1) begin
            state_d = AFTER_COLLECT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (res_valid_i && (cnt_q == LAST_CNT)) begin
          state_d = AFTER_COLLECT;
        end else begin
          state_d = COLLECT;
        end
      end
      SUB: begin
        if (cnt_q == LAST_CNT) begin
          state_d = OUT;
        end else begin
          state_d = SUB;
        end
      end
      OUT: begin
        if (valid_q && result_ready_i) begin
          if (!res_valid_i) begin
            state_d = IDLE;
          end else if (s == 1) begin
            state_d = AFTER_COLLECT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values. The first OUT cycle loads the selected result.
  always_comb begin
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    result_d   = result_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    wr_idx_s   = cnt_q;
`ifdef FIOS_FINAL_SUB_EN
    sub_en_s   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          wr_en_s  = 1'b1;
          wr_idx_s = ZERO_CNT;
          cnt_d    = FIRST_CNT;
          borrow_d = 1'b0;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      COLLECT: begin
        if (res_valid_i) begin
          wr_en_s  = 1'b1;
          wr_idx_s = cnt_q;
          if (cnt_q == LAST_CNT) begin
            cnt_d    = ZERO_CNT;
            borrow_d = 1'b0;
          end else begin
            cnt_d    = cnt_q + ONE_CNT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      SUB: begin
`ifdef FIOS_FINAL_SUB_EN
        sub_en_s = 1'b1;
        borrow_d = diff_s[W];
`endif
        if (cnt_q == LAST_CNT) begin
          cnt_d = ZERO_CNT;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
        overflow_d = overflow_q | res_valid_i;
      end
      OUT: begin
        if (!valid_q) begin
          valid_d    = 1'b1;
          result_d   = sel_s;
          overflow_d = overflow_q | res_valid_i;
        end else if (result_ready_i) begin
          valid_d = 1'b0;
          if (res_valid_i) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ZERO_CNT;
            cnt_d    = FIRST_CNT;
            borrow_d = 1'b0;
          end else begin
            cnt_d    = cnt_q;
          end
        end else begin
          overflow_d = overflow_q | res_valid_i;
        end
      end
      default: begin
        cnt_d = ZERO_CNT;
      end
    endcase
  end

  // busy_o is registered and tracks the state being entered.
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // Result word capture into the R bank.
  always_comb begin
    r_d = r_q;
    if (wr_en_s) begin
      r_d[wr_idx_s*W +: W] = res_i;
    end else begin
      r_d = r_q;
    end
  end

  // R bank storage. Stale words are always overwritten by a full new stream.
  always_ff @(posedge clock_i) begin
    r_q <= r_d;
  end

  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector with s=4.
// Expected values cover both builds, with and without FIOS_FINAL_SUB_EN.
module tb_fios_res_collector;

  localparam int S  = 4;
  localparam int WW = 17;
  localparam int RW = S * WW;

`ifdef FIOS_FINAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int EXP_LAT = SUB_EN ? 5 : 1;

  logic          clk;
  logic          reset_i;
  logic          res_valid_i;
  logic [WW-1:0] res_i;
  logic [RW-1:0] p_i;
  logic          busy_o;
  logic [RW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          overflow_o;

  int n_cmp;
  int n_err;
  int lat;
  logic [RW-1:0] snap;

  fios_res_collector #(.s(S), .W(WW)) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .res_valid_i    (res_valid_i),
    .res_i          (res_i),
    .p_i            (p_i),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .overflow_o     (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    res_valid_i = 1'b1;
    res_i       = w;
    @(posedge clk);
    #1;
    res_valid_i = 1'b0;
    res_i       = '0;
  endtask

  task automatic stream(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        input logic [WW-1:0] w2, input logic [WW-1:0] w3,
                        input int gap);
    logic [WW-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      send_word(w[i]);
      if (i < 3) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake();
    result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    result_ready_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_i        = 1'b1;
    res_valid_i    = 1'b0;
    res_i          = '0;
    result_ready_i = 1'b0;
    p_i            = {17'd0, 17'd0, 17'd0, 17'd5};
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Reset state
    chk("rst_busy",     RW'(busy_o),         RW'(0));
    chk("rst_valid",    RW'(result_valid_o), RW'(0));
    chk("rst_result",   result_o,            RW'(0));
    chk("rst_overflow", RW'(overflow_o),     RW'(0));

    // Simple reduction: 7 - 5 = 2
    send_word(17'd7);
    chk("busy_collect", RW'(busy_o), RW'(1));
    send_word(17'd0); send_word(17'd0); send_word(17'd0);
    wait_valid(lat);
    chk("simple_lat",    RW'(lat), RW'(EXP_LAT));
    chk("simple_result", result_o, SUB_EN ? RW'(2) : RW'(7));
    chk("simple_busy",   RW'(busy_o), RW'(1));
    handshake();
    chk("hs_valid", RW'(result_valid_o), RW'(0));
    chk("hs_busy",  RW'(busy_o),         RW'(0));

    // No subtraction: 3 < 5
    stream(17'd3, 17'd0, 17'd0, 17'd0, 0);
    wait_valid(lat);
    chk("nosub_lat",    RW'(lat), RW'(EXP_LAT));
    chk("nosub_result", result_o, RW'(3));
    handshake();

    // Equal case: 5 - 5 = 0
    stream(17'd5, 17'd0, 17'd0, 17'd0, 0);
    wait_valid(lat);
    chk("equal_result", result_o, SUB_EN ? RW'(0) : RW'(5));
    handshake();

    // Borrow propagation: 2*2^17 - (2^17 + 1) = 0x1FFFF
    p_i = {17'd0, 17'd0, 17'd1, 17'd1};
    stream(17'd0, 17'd2, 17'd0, 17'd0, 0);
    wait_valid(lat);
    chk("borrow_result", result_o, SUB_EN ? 68'h1FFFF : 68'h40000);
    handshake();

    // Gappy input with backpressure, then overflow during OUT
    p_i = {17'd0, 17'd0, 17'd0, 17'd5};
    stream(17'd9, 17'd0, 17'd0, 17'd0, 2);
    wait_valid(lat);
    chk("gap_lat",    RW'(lat), RW'(EXP_LAT));
    chk("gap_result", result_o, SUB_EN ? RW'(4) : RW'(9));
    snap = result_o;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid",    RW'(result_valid_o), RW'(1));
    chk("bp_result",   result_o,            SUB_EN ? RW'(4) : RW'(9));
    chk("bp_overflow", RW'(overflow_o),     RW'(0));
    send_word(17'd77);
    chk("ovf_set",    RW'(overflow_o),     RW'(1));
    chk("ovf_result", result_o,            snap);
    chk("ovf_valid",  RW'(result_valid_o), RW'(1));
    handshake();
    chk("ovf_sticky", RW'(overflow_o), RW'(1));

    // Back-to-back: ready together with the next word 0
    stream(17'd6, 17'd0, 17'd0, 17'd0, 0);
    wait_valid(lat);
    chk("b2b_first", result_o, SUB_EN ? RW'(1) : RW'(6));
    result_ready_i = 1'b1;
    send_word(17'd8);
    result_ready_i = 1'b0;
    chk("b2b_busy",  RW'(busy_o),         RW'(1));
    chk("b2b_valid", RW'(result_valid_o), RW'(0));
    send_word(17'd0); send_word(17'd0); send_word(17'd0);
    wait_valid(lat);
    chk("b2b_lat",    RW'(lat), RW'(EXP_LAT));
    chk("b2b_second", result_o, SUB_EN ? RW'(3) : RW'(8));
    handshake();

    // Reset mid-collection, then a fresh stream
    send_word(17'd11);
    send_word(17'd0);
    chk("mid_busy", RW'(busy_o), RW'(1));
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("mrst_busy",     RW'(busy_o),         RW'(0));
    chk("mrst_valid",    RW'(result_valid_o), RW'(0));
    chk("mrst_overflow", RW'(overflow_o),     RW'(0));
    chk("mrst_result",   result_o,            RW'(0));
    stream(17'd12, 17'd0, 17'd0, 17'd0, 0);
    wait_valid(lat);
    chk("fresh_lat",    RW'(lat), RW'(EXP_LAT));
    chk("fresh_result", result_o, SUB_EN ? RW'(7) : RW'(12));
    handshake();
    chk("fresh_idle", RW'(busy_o), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
